// File: rtl/scene_pkg.sv
// Scene sequencer shared definitions: scene codes seen by the renderer,
// the sequencer state encoding and a counter-width helper.
package scene_pkg;

    // Scene codes as presented to the VGA renderer
    localparam logic [1:0] SCN_TITLE = 2'b00;
    localparam logic [1:0] SCN_PLAY  = 2'b01;
    localparam logic [1:0] SCN_OVER  = 2'b10;

    // PAUSE is part of the encoding even when the pause feature is not built
    typedef enum logic [2:0] {
        INIT,
        TITLE,
        COUNTDOWN,
        PLAY,
        PAUSE,
        OVER_LOCK,
        OVER
    } state_t;

    // Scene code the renderer sees for each sequencer state
    function automatic logic [1:0] scene_of(input state_t s);
        case (s)
            COUNTDOWN, PLAY, PAUSE: return SCN_PLAY;
            OVER_LOCK, OVER:        return SCN_OVER;
            default:                return SCN_TITLE;
        endcase
    endfunction

    // Bits needed to hold 0..v; never narrower than one bit so a zero
    // parameter still yields a legal vector
    function automatic int cnt_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter stepped by a tick enable. Saturates at zero and
// reports it through a zero flag. Load has priority over the tick.
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         zero
);

    // Count register: reload, or step down on tick until zero
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/scene_sequencer.sv
// Game scene sequencer: TITLE -> COUNTDOWN -> PLAY -> OVER_LOCK -> OVER -> TITLE,
// with a start countdown, a post-hit key lockout and a blanking fade on every
// scene change. Drives game_run / clear_game towards the game datapath.
// Optional pause state is built when the macro SCENE_PAUSE_EN is defined.
module scene_sequencer
    import scene_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 60,
    parameter int COUNT_DIGITS    = 3,
    parameter int LOCK_TICKS      = 60,
    parameter int FADE_TICKS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       hit,
    input  logic       key_press,
    input  logic       pause_req,
    input  logic [1:0] init_scene,
    output logic [1:0] scene,
    output logic       game_run,
    output logic       clear_game,
    output logic       blank,
    output logic [1:0] cd_digit
);

    // The digit and lock phases never overlap, so they share one timer
    localparam int TW = cnt_width((TICKS_PER_DIGIT > LOCK_TICKS) ? TICKS_PER_DIGIT : LOCK_TICKS);
    localparam int FW = cnt_width(FADE_TICKS);

    localparam logic [TW-1:0] DIGIT_RELOAD = TW'(TICKS_PER_DIGIT);
    localparam logic [TW-1:0] LOCK_RELOAD  = TW'(LOCK_TICKS);
    localparam logic [FW-1:0] FADE_RELOAD  = FW'(FADE_TICKS);
    localparam logic [1:0]    CD_START     = 2'(COUNT_DIGITS);
    localparam logic          FADE_ON      = (FADE_TICKS != 0);

    state_t          state;
    state_t          nxt_state;
    logic [1:0]      nxt_cd;
    logic            nxt_clear;
    logic            evt_taken;

    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_tick;
    logic [TW-1:0]   tmr_cnt;
    logic            tmr_zero;

    logic            fade_load;
    logic            fade_tick;
    logic [FW-1:0]   fade_cnt;
    logic            fade_zero;
    logic            fade_next_nz;

`ifndef SCENE_PAUSE_EN
    // Pause request is accepted on the port but has no function in this build
    logic unused_pause;
    assign unused_pause = pause_req;
`endif

    // Transition decode: next state, countdown digit and timer reloads.
    // Priority among events: hit, then pause_req, then key_press.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        nxt_state = state;
        nxt_cd    = cd_digit;
        nxt_clear = 1'b0;
        evt_taken = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = DIGIT_RELOAD;

        case (state)
            INIT: begin
                if (init_scene == 2'b01) begin
                    nxt_state = COUNTDOWN;
                    nxt_clear = 1'b1;
                    nxt_cd    = CD_START;
                    tmr_load  = 1'b1;
                end else if (init_scene == 2'b10) begin
                    nxt_state = OVER;
                end else begin
                    nxt_state = TITLE;
                end
            end
            TITLE: begin
                if (key_press) begin
                    nxt_state = COUNTDOWN;
                    nxt_clear = 1'b1;
                    nxt_cd    = CD_START;
                    tmr_load  = 1'b1;
                    evt_taken = 1'b1;
                end
            end
            COUNTDOWN: begin
                // Expire on the tick that would bring the digit timer to zero
                if (tick && (tmr_cnt <= TW'(1))) begin
                    if (cd_digit <= 2'd1) begin
                        nxt_state = PLAY;
                    end else begin
                        nxt_cd   = cd_digit - 2'd1;
                        tmr_load = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (hit) begin
                    nxt_state = OVER_LOCK;
                    tmr_load  = 1'b1;
                    tmr_val   = LOCK_RELOAD;
                    evt_taken = 1'b1;
`ifdef SCENE_PAUSE_EN
                end else if (pause_req) begin
                    nxt_state = PAUSE;
                    evt_taken = 1'b1;
`endif
                end
            end
`ifdef SCENE_PAUSE_EN
            PAUSE: begin
                if (pause_req) begin
                    nxt_state = PLAY;
                    evt_taken = 1'b1;
                end else if (key_press) begin
                    nxt_state = TITLE;
                    evt_taken = 1'b1;
                end
            end
`endif
            OVER_LOCK: begin
                if (tmr_zero) begin
                    nxt_state = OVER;
                end
            end
            OVER: begin
                if (key_press) begin
                    nxt_state = TITLE;
                    evt_taken = 1'b1;
                end
            end
            default: begin
                nxt_state = INIT;
            end
        endcase

        if (nxt_state != COUNTDOWN) begin
            nxt_cd = 2'd0;
        end
    end

    // Timer stepping: a tick coinciding with an accepted event is dropped.
    // Leaving INIT counts as a scene change so blanking ends cleanly after reset.
    assign tmr_tick  = tick && !evt_taken && ((state == COUNTDOWN) || (state == OVER_LOCK));
    assign fade_load = (state == INIT) || (scene_of(nxt_state) != scene);
    assign fade_tick = tick && !evt_taken && (state != PAUSE);

    // Blank stays up while the fade counter will still be non-zero after this edge
    assign fade_next_nz = fade_load ? FADE_ON
                                    : (!fade_zero && !(fade_tick && (fade_cnt == FW'(1))));

    tick_timer #(.W(TW)) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick),
        .count    (tmr_cnt),
        .zero     (tmr_zero)
    );

    tick_timer #(.W(FW)) u_fade_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (fade_load),
        .load_val (FADE_RELOAD),
        .tick     (fade_tick),
        .count    (fade_cnt),
        .zero     (fade_zero)
    );

    // State register with registered renderer/datapath outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            scene      <= SCN_TITLE;
            game_run   <= 1'b0;
            clear_game <= 1'b0;
            blank      <= 1'b1;
            cd_digit   <= 2'd0;
        end else begin
            state      <= nxt_state;
            scene      <= scene_of(nxt_state);
            game_run   <= (nxt_state == PLAY);
            clear_game <= nxt_clear;
            blank      <= (nxt_state != PAUSE) && fade_next_nz;
            cd_digit   <= nxt_cd;
        end
    end

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed testbench for scene_sequencer with default parameters
// (60 ticks/digit, 3 digits, 60 lock ticks, 16 fade ticks).
// Pause checks follow SCENE_PAUSE_EN, compiled with the same defines as the RTL.
module tb_scene_sequencer;
    import scene_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       hit;
    logic       key_press;
    logic       pause_req;
    logic [1:0] init_scene;
    logic [1:0] scene;
    logic       game_run;
    logic       clear_game;
    logic       blank;
    logic [1:0] cd_digit;

    int checks = 0;
    int errors = 0;

    scene_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .hit        (hit),
        .key_press  (key_press),
        .pause_req  (pause_req),
        .init_scene (init_scene),
        .scene      (scene),
        .game_run   (game_run),
        .clear_game (clear_game),
        .blank      (blank),
        .cd_digit   (cd_digit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    task automatic press_key();
        key_press = 1'b1;
        step();
        key_press = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        tick       = 1'b0;
        hit        = 1'b0;
        key_press  = 1'b0;
        pause_req  = 1'b0;
        init_scene = 2'b10;

        // 1: reset values, start in game over, key to title, fade length
        repeat (3) @(posedge clk);
        #1;
        check("rst_scene", scene, SCN_TITLE);
        check("rst_game_run", game_run, 1'b0);
        check("rst_clear", clear_game, 1'b0);
        check("rst_blank", blank, 1'b1);
        check("rst_cd", cd_digit, 2'd0);

        rst = 1'b0;
        step();
        check("init_over_scene", scene, SCN_OVER);
        check("init_over_clear", clear_game, 1'b0);
        press_key();
        check("over_key_title", scene, SCN_TITLE);
        check("fade_start", blank, 1'b1);
        ticks(15);
        check("fade_15", blank, 1'b1);
        ticks(1);
        check("fade_16", blank, 1'b0);

        // 2: countdown 3,2,1 then play after exactly 180 ticks
        press_key();
        check("cd_clear_pulse", clear_game, 1'b1);
        check("cd_start_digit", cd_digit, 2'd3);
        check("cd_scene", scene, SCN_PLAY);
        check("cd_run", game_run, 1'b0);
        step();
        check("cd_clear_one_cycle", clear_game, 1'b0);

        // 3a: hit ignored during countdown
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("cd_hit_ignored_scene", scene, SCN_PLAY);
        check("cd_hit_ignored_digit", cd_digit, 2'd3);

        ticks(59);
        check("cd_59", cd_digit, 2'd3);
        ticks(1);
        check("cd_60", cd_digit, 2'd2);
        ticks(59);
        check("cd_119", cd_digit, 2'd2);
        ticks(1);
        check("cd_120", cd_digit, 2'd1);
        ticks(59);
        check("cd_179_digit", cd_digit, 2'd1);
        check("cd_179_run", game_run, 1'b0);
        ticks(1);
        check("cd_180_run", game_run, 1'b1);
        check("cd_180_digit", cd_digit, 2'd0);

        // 3b: hit in play, key lockout, key accepted after lockout
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("play_hit_scene", scene, SCN_OVER);
        check("play_hit_run", game_run, 1'b0);
        press_key();
        check("lock_key_0", scene, SCN_OVER);
        ticks(59);
        press_key();
        check("lock_key_59", scene, SCN_OVER);
        ticks(1);
        step();
        press_key();
        check("lock_done_key", scene, SCN_TITLE);

        // 4: hit and key together in play -> lockout, key not consumed
        press_key();
        ticks(180);
        check("t4_play", game_run, 1'b1);
        hit       = 1'b1;
        key_press = 1'b1;
        step();
        hit       = 1'b0;
        key_press = 1'b0;
        check("t4_hit_wins", scene, SCN_OVER);
        ticks(60);
        step();
        step();
        check("t4_key_not_kept", scene, SCN_OVER);
        press_key();
        check("t4_title", scene, SCN_TITLE);

        // 5: asynchronous reset mid-countdown, restart into title
        press_key();
        ticks(10);
        check("t5_cd", cd_digit, 2'd3);
        rst = 1'b1;
        #1;
        check("t5_async_scene", scene, SCN_TITLE);
        check("t5_async_cd", cd_digit, 2'd0);
        check("t5_async_blank", blank, 1'b1);
        init_scene = 2'b11;
        step();
        step();
        rst = 1'b0;
        step();
        check("t5_init_title", scene, SCN_TITLE);
        check("t5_no_clear", clear_game, 1'b0);
        press_key();
        check("t5_title_key", clear_game, 1'b1);

        // 6: pause behaviour
        ticks(180);
        check("t6_play", game_run, 1'b1);
        pause_req = 1'b1;
        step();
        pause_req = 1'b0;
`ifdef SCENE_PAUSE_EN
        check("t6_paused_run", game_run, 1'b0);
        check("t6_paused_blank", blank, 1'b0);
        hit = 1'b1;
        ticks(100);
        hit = 1'b0;
        check("t6_pause_hold_run", game_run, 1'b0);
        check("t6_pause_hit_ignored", scene, SCN_PLAY);
        pause_req = 1'b1;
        step();
        pause_req = 1'b0;
        check("t6_resume_run", game_run, 1'b1);
`else
        check("t6_no_pause_run", game_run, 1'b1);
        ticks(5);
        check("t6_no_pause_scene", scene, SCN_PLAY);
`endif
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("t6_hit_after", scene, SCN_OVER);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
